frame_load_controller: RTL and testbench

- Sits in the system clock domain between the SPI byte receiver (after CDC synchronisation) and the pixel frame buffer / edge-detection core.
- Decodes command bytes from the MCU and streams LOAD payload bytes into the frame buffer with an auto-incrementing address.
- Gates and sequences accelerator start/done.
- Reports frame-valid, busy and error status.

---
 rtl/frame_load_controller.sv | 166 ++++++++++++++++
 tb/tb_frame_load_controller.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/frame_load_controller.sv
// frame_load_controller
// Decodes MCU command bytes, streams LOAD payload into the pixel frame buffer
// with an auto-incrementing address, and sequences the edge-detection core.
module frame_load_controller #(
    parameter int IMG_WIDTH  = 64,
    parameter int IMG_HEIGHT = 64,
    parameter int PIXEL_BITS = 8,
    parameter int ADDR_BITS  = 12
) (
    input  logic                  clk,
    input  logic                  nRst,
    input  logic                  rxValid,
    input  logic [PIXEL_BITS-1:0] rxData,
    input  logic                  csActive,
    output logic                  bufWe,
    output logic [ADDR_BITS-1:0]  bufAddr,
    output logic [PIXEL_BITS-1:0] bufData,
    output logic                  accelStart,
    input  logic                  accelDone,
    output logic                  frameLoaded,
    output logic                  ctrlBusy,
    output logic                  loadError
);

    localparam int FRAME_PIXELS = IMG_WIDTH * IMG_HEIGHT;
    localparam logic [ADDR_BITS-1:0]  LAST_PIX    = ADDR_BITS'(FRAME_PIXELS - 1);
    localparam logic [ADDR_BITS-1:0]  ADDR_ONE    = ADDR_BITS'(1);
    localparam logic [PIXEL_BITS-1:0] CMD_LOAD    = PIXEL_BITS'(8'h01);
    localparam logic [PIXEL_BITS-1:0] CMD_START   = PIXEL_BITS'(8'h02);
    localparam logic [PIXEL_BITS-1:0] CMD_CLR_ERR = PIXEL_BITS'(8'h03);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [ADDR_BITS-1:0]    cnt_q, cnt_d;
    logic                    buf_we_q, buf_we_d;
    logic [ADDR_BITS-1:0]    buf_addr_q, buf_addr_d;
    logic [PIXEL_BITS-1:0]   buf_data_q, buf_data_d;
    logic                    accel_start_q, accel_start_d;
    logic                    frame_loaded_q, frame_loaded_d;
    logic                    load_error_q, load_error_d;

    // A write at the last pixel finishes the frame, even if chip select drops in the same cycle.
    logic last_write;
    assign last_write = rxValid && (cnt_q == LAST_PIX);

    // State register
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode: commands in IDLE, completion/abort in LOAD, done in RUN
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (rxValid) begin
                    if (rxData == CMD_LOAD) begin
                        state_d = LOAD;
                    end else if (rxData == CMD_START && frame_loaded_q) begin
                        state_d = RUN;
                    end
                end
            end
            LOAD: begin
                if (last_write || !csActive) begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                if (accelDone) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output and datapath decode; RUN deliberately ignores every received byte
    always_comb begin
        buf_we_d       = 1'b0;
        buf_addr_d     = buf_addr_q;
        buf_data_d     = buf_data_q;
        accel_start_d  = 1'b0;
        cnt_d          = cnt_q;
        frame_loaded_d = frame_loaded_q;
        load_error_d   = load_error_q;
        ctrlBusy       = (state_q != IDLE);
        case (state_q)
            IDLE: begin
                if (rxValid) begin
                    if (rxData == CMD_LOAD) begin
                        frame_loaded_d = 1'b0;
                        cnt_d          = '0;
                    end else if (rxData == CMD_START) begin
                        if (frame_loaded_q) begin
                            accel_start_d = 1'b1;
                        end else begin
                            load_error_d = 1'b1;
                        end
                    end else if (rxData == CMD_CLR_ERR) begin
                        load_error_d = 1'b0;
                    end else begin
                        load_error_d = 1'b1;
                    end
                end
            end
            LOAD: begin
                if (rxValid) begin
                    buf_we_d   = 1'b1;
                    buf_addr_d = cnt_q;
                    buf_data_d = rxData;
                end
                if (last_write) begin
                    // Counter holds at the last pixel rather than wrapping.
                    frame_loaded_d = 1'b1;
                end else begin
                    if (rxValid) begin
                        cnt_d = cnt_q + ADDR_ONE;
                    end
                    if (!csActive) begin
                        load_error_d = 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    // Datapath and status registers; everything clears on reset so no partial load survives
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            cnt_q          <= '0;
            buf_we_q       <= 1'b0;
            buf_addr_q     <= '0;
            buf_data_q     <= '0;
            accel_start_q  <= 1'b0;
            frame_loaded_q <= 1'b0;
            load_error_q   <= 1'b0;
        end else begin
            cnt_q          <= cnt_d;
            buf_we_q       <= buf_we_d;
            buf_addr_q     <= buf_addr_d;
            buf_data_q     <= buf_data_d;
            accel_start_q  <= accel_start_d;
            frame_loaded_q <= frame_loaded_d;
            load_error_q   <= load_error_d;
        end
    end

    assign bufWe       = buf_we_q;
    assign bufAddr     = buf_addr_q;
    assign bufData     = buf_data_q;
    assign accelStart  = accel_start_q;
    assign frameLoaded = frame_loaded_q;
    assign loadError   = load_error_q;

endmodule

// File: tb/tb_frame_load_controller.sv
// Directed testbench for frame_load_controller on a 4x4 frame.
module tb_frame_load_controller;

    localparam int PB = 8;
    localparam int AB = 4;

    logic          clk = 1'b0;
    logic          nRst = 1'b0;
    logic          rxValid = 1'b0;
    logic [PB-1:0] rxData = '0;
    logic          csActive = 1'b0;
    logic          bufWe;
    logic [AB-1:0] bufAddr;
    logic [PB-1:0] bufData;
    logic          accelStart;
    logic          accelDone = 1'b0;
    logic          frameLoaded;
    logic          ctrlBusy;
    logic          loadError;

    int pass_cnt = 0;
    int total_cnt = 0;
    int wr_cnt = 0;
    int wr_snap;

    frame_load_controller #(
        .IMG_WIDTH(4), .IMG_HEIGHT(4), .PIXEL_BITS(PB), .ADDR_BITS(AB)
    ) dut (
        .clk(clk), .nRst(nRst), .rxValid(rxValid), .rxData(rxData),
        .csActive(csActive), .bufWe(bufWe), .bufAddr(bufAddr), .bufData(bufData),
        .accelStart(accelStart), .accelDone(accelDone), .frameLoaded(frameLoaded),
        .ctrlBusy(ctrlBusy), .loadError(loadError)
    );

    always #5 clk = ~clk;

    // Count every write pulse seen on the buffer port
    always @(posedge clk) if (bufWe === 1'b1) wr_cnt++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Present one byte for one clock (with chosen chip select), then sample 1ns after the edge
    task automatic send(input logic [PB-1:0] b, input logic cs);
        @(negedge clk);
        rxValid  = 1'b1;
        rxData   = b;
        csActive = cs;
        @(posedge clk);
        #1;
        rxValid = 1'b0;
    endtask

    task automatic idle_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic load_pixel(input logic [PB-1:0] b, input int addr, input logic cs);
        send(b, cs);
        check("we", 32'(bufWe), 32'd1);
        check("addr", 32'(bufAddr), 32'(addr));
        check("data", 32'(bufData), 32'(b));
    endtask

    initial begin
        // Reset state
        #12;
        check("rst_we", 32'(bufWe), 0);
        check("rst_addr", 32'(bufAddr), 0);
        check("rst_busy", 32'(ctrlBusy), 0);
        check("rst_loaded", 32'(frameLoaded), 0);
        check("rst_err", 32'(loadError), 0);
        @(negedge clk);
        nRst = 1'b1;
        csActive = 1'b1;

        // Clean load
        send(8'h01, 1'b1);
        check("load_busy", 32'(ctrlBusy), 1);
        check("load_cmd_no_we", 32'(bufWe), 0);
        for (int i = 0; i < 16; i++) begin
            load_pixel(8'(8'h10 + i), i, 1'b1);
            if (i == 14) check("loaded_early", 32'(frameLoaded), 0);
        end
        check("clean_loaded", 32'(frameLoaded), 1);
        check("clean_busy", 32'(ctrlBusy), 0);
        check("clean_err", 32'(loadError), 0);
        idle_cycle();
        check("clean_we_end", 32'(bufWe), 0);

        // Start sequencing
        send(8'h02, 1'b1);
        check("start_pulse", 32'(accelStart), 1);
        check("run_busy", 32'(ctrlBusy), 1);
        idle_cycle();
        check("start_one_cycle", 32'(accelStart), 0);
        wr_snap = wr_cnt;
        send(8'hAA, 1'b1);
        check("run_aa_no_we", 32'(bufWe), 0);
        send(8'h01, 1'b1);
        check("run_01_no_we", 32'(bufWe), 0);
        check("run_no_err", 32'(loadError), 0);
        check("run_still_busy", 32'(ctrlBusy), 1);
        @(negedge clk);
        accelDone = 1'b1;
        @(posedge clk);
        #1;
        accelDone = 1'b0;
        check("done_idle", 32'(ctrlBusy), 0);
        check("done_loaded", 32'(frameLoaded), 1);
        check("run_no_writes", 32'(wr_cnt - wr_snap), 0);
        send(8'h02, 1'b1);
        check("restart_pulse", 32'(accelStart), 1);
        // Byte arriving together with accelDone is discarded
        @(negedge clk);
        accelDone = 1'b1;
        rxValid   = 1'b1;
        rxData    = 8'h01;
        @(posedge clk);
        #1;
        accelDone = 1'b0;
        rxValid   = 1'b0;
        check("done_byte_idle", 32'(ctrlBusy), 0);
        idle_cycle();
        check("done_byte_dropped", 32'(ctrlBusy), 0);
        check("done_byte_loaded", 32'(frameLoaded), 1);
        // accelDone in IDLE is ignored
        @(negedge clk);
        accelDone = 1'b1;
        idle_cycle();
        accelDone = 1'b0;
        check("done_idle_ignored", 32'(ctrlBusy), 0);
        check("done_idle_loaded", 32'(frameLoaded), 1);

        // Premature abort
        wr_snap = wr_cnt;
        send(8'h01, 1'b1);
        check("abort_loaded_clr", 32'(frameLoaded), 0);
        for (int i = 0; i < 5; i++) load_pixel(8'(8'h40 + i), i, 1'b1);
        @(negedge clk);
        csActive = 1'b0;
        idle_cycle();
        check("abort_err", 32'(loadError), 1);
        check("abort_loaded", 32'(frameLoaded), 0);
        check("abort_idle", 32'(ctrlBusy), 0);
        idle_cycle();
        idle_cycle();
        check("abort_writes", 32'(wr_cnt - wr_snap), 5);
        send(8'h02, 1'b1);
        check("abort_no_start", 32'(accelStart), 0);
        check("abort_err_kept", 32'(loadError), 1);
        check("abort_start_idle", 32'(ctrlBusy), 0);

        // Boundary: last pixel coincides with chip select falling
        send(8'h03, 1'b1);
        check("clr_err", 32'(loadError), 0);
        send(8'h01, 1'b1);
        for (int i = 0; i < 15; i++) load_pixel(8'(8'h60 + i), i, 1'b1);
        load_pixel(8'h6F, 15, 1'b0);
        check("edge16_loaded", 32'(frameLoaded), 1);
        check("edge16_err", 32'(loadError), 0);
        check("edge16_idle", 32'(ctrlBusy), 0);
        @(negedge clk);
        csActive = 1'b1;

        // Boundary: 15th pixel coincides with chip select falling
        send(8'h01, 1'b1);
        for (int i = 0; i < 14; i++) load_pixel(8'(8'h80 + i), i, 1'b1);
        load_pixel(8'h8E, 14, 1'b0);
        check("edge15_err", 32'(loadError), 1);
        check("edge15_loaded", 32'(frameLoaded), 0);
        check("edge15_idle", 32'(ctrlBusy), 0);
        idle_cycle();
        check("edge15_no_more_we", 32'(bufWe), 0);
        @(negedge clk);
        csActive = 1'b1;

        // Command errors and clear
        send(8'h03, 1'b1);
        check("clr2", 32'(loadError), 0);
        send(8'h7E, 1'b1);
        check("bad_cmd_err", 32'(loadError), 1);
        check("bad_cmd_idle", 32'(ctrlBusy), 0);
        send(8'h03, 1'b1);
        check("clr3", 32'(loadError), 0);

        // Async reset mid-LOAD
        send(8'h01, 1'b1);
        for (int i = 0; i < 8; i++) load_pixel(8'(8'hC0 + i), i, 1'b1);
        @(negedge clk);
        #2;
        nRst = 1'b0;
        #1;
        check("arst_we", 32'(bufWe), 0);
        check("arst_addr", 32'(bufAddr), 0);
        check("arst_data", 32'(bufData), 0);
        check("arst_busy", 32'(ctrlBusy), 0);
        check("arst_loaded", 32'(frameLoaded), 0);
        check("arst_err", 32'(loadError), 0);
        check("arst_start", 32'(accelStart), 0);
        @(negedge clk);
        nRst = 1'b1;
        send(8'h02, 1'b1);
        check("start_unloaded_err", 32'(loadError), 1);
        check("start_unloaded_pulse", 32'(accelStart), 0);
        send(8'h01, 1'b1);
        for (int i = 0; i < 16; i++) load_pixel(8'(8'hD0 + i), i, 1'b1);
        check("reload_loaded", 32'(frameLoaded), 1);
        check("reload_idle", 32'(ctrlBusy), 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
